// File: rtl/macro_wb_demux.sv
// Wishbone demux: gives each user macro a private address slot with its own strobe and response path.
// It also serves a local status slot and answers unanswered requests with an error word after a timeout.
module macro_wb_demux #(
  parameter int          NUM_MACROS     = 8,
  parameter int          SLOT_LSB       = 20,
  parameter int          SLOT_BITS      = 4,
  parameter logic [7:0]  BASE_ADDR      = 8'h30,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  input  logic [NUM_MACROS-1:0]      active,
  output logic [NUM_MACROS-1:0]      m_cyc_o,
  output logic [NUM_MACROS-1:0]      m_stb_o,
  output logic                       m_we_o,
  output logic [3:0]                 m_sel_o,
  output logic [31:0]                m_adr_o,
  output logic [31:0]                m_dat_o,
  input  logic [NUM_MACROS-1:0]      m_ack_i,
  input  logic [32*NUM_MACROS-1:0]   m_dat_i,
  output logic                       irq_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [SLOT_BITS-1:0] LOCAL_SLOT = SLOT_BITS'(NUM_MACROS);

  logic [1:0]            r_state;
  logic [SLOT_BITS-1:0]  r_slot;
  logic [NUM_MACROS-1:0] r_stb;
  logic [TW-1:0]         r_timer;
  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_adr;
  logic [31:0]           r_wdat;
  logic [15:0]           r_tcnt;
  logic                  r_pending;
  logic                  r_irq_en;
  logic                  r_irq;
  logic [SLOT_BITS-1:0]  r_last_slot;

  logic                  w_hit;
  logic [SLOT_BITS-1:0]  w_slot;
  logic                  w_fwd;
  logic [NUM_MACROS-1:0] w_onehot;
  logic                  w_sel_ack;
  logic [31:0]           w_sel_dat;
  logic                  w_local;
  logic [31:0]           w_loc_rd;
  logic                  w_loc_wr;
  logic                  w_clr;
  logic                  w_tmo_hit;
  logic                  w_timeout;
  logic [15:0]           w_tcnt_base;

  assign w_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR);
  assign w_slot  = wbs_adr_i[SLOT_LSB +: SLOT_BITS];
  assign w_local = (w_slot == LOCAL_SLOT);

  // Loop muxes keep slot indexing in range for any NUM_MACROS / SLOT_BITS pairing.
  always_comb begin
    w_fwd     = 1'b0;
    w_onehot  = '0;
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < NUM_MACROS; i++) begin
      if (w_slot == SLOT_BITS'(i)) begin
        w_fwd       = active[i];
        w_onehot[i] = 1'b1;
      end
      if (r_slot == SLOT_BITS'(i)) begin
        w_sel_ack = m_ack_i[i];
        w_sel_dat = m_dat_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_loc_rd = '0;
    case (wbs_adr_i[3:2])
      2'd0:    w_loc_rd = 32'(active);
      2'd1:    w_loc_rd = {r_pending, 15'b0, r_tcnt};
      2'd2:    w_loc_rd = {31'b0, r_irq_en};
      default: w_loc_rd = 32'(r_last_slot);
    endcase
  end

  assign w_loc_wr    = (r_state == S_IDLE) & w_hit & w_local & wbs_we_i;
  assign w_clr       = w_loc_wr & (wbs_adr_i[3:2] == 2'd1);
  assign w_tmo_hit   = (r_timer == TW'(TIMEOUT_CYCLES));
  // A macro ack in the expiry cycle wins; a host abort beats both.
  assign w_timeout   = (r_state == S_FWD) & wbs_cyc_i & ~w_sel_ack & w_tmo_hit;
  assign w_tcnt_base = w_clr ? 16'h0 : r_tcnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
      r_stb   <= '0;
      r_timer <= '0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_wdat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            if (w_fwd) begin
              r_state <= S_FWD;
              r_slot  <= w_slot;
              r_stb   <= w_onehot;
              r_timer <= '0;
              r_we    <= wbs_we_i;
              r_sel   <= wbs_sel_i;
              r_adr   <= wbs_adr_i;
              r_wdat  <= wbs_dat_i;
            end else begin
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              r_dat   <= w_local ? w_loc_rd : ERR_DATA;
            end
          end
        end
        S_FWD: begin
          if (!wbs_cyc_i) begin
            r_stb   <= '0;
            r_state <= S_IDLE;
          end else if (w_sel_ack) begin
            r_stb   <= '0;
            r_dat   <= w_sel_dat;
            r_ack   <= 1'b1;
            r_state <= S_RESP;
          end else if (w_tmo_hit) begin
            r_stb   <= '0;
            r_dat   <= ERR_DATA;
            r_ack   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESP: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tcnt      <= '0;
      r_pending   <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_last_slot <= '0;
    end else begin
      if (w_timeout) begin
        r_tcnt      <= (w_tcnt_base == 16'hFFFF) ? w_tcnt_base : w_tcnt_base + 16'h1;
        r_last_slot <= r_slot;
      end else begin
        r_tcnt <= w_tcnt_base;
      end
      r_pending <= w_timeout | (r_pending & ~w_clr);
      if (w_loc_wr && (wbs_adr_i[3:2] == 2'd2) && wbs_sel_i[0])
        r_irq_en <= wbs_dat_i[0];
      r_irq <= r_pending & r_irq_en;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign m_cyc_o   = r_stb;
  assign m_stb_o   = r_stb;
  assign m_we_o    = r_we;
  assign m_sel_o   = r_sel;
  assign m_adr_o   = r_adr;
  assign m_dat_o   = r_wdat;
  assign irq_o     = r_irq;

endmodule
